eth_rx_dest_filter: RTL and testbench
=====================================

Name: eth_rx_dest_filter

Overview:
Sits directly downstream of the Ethernet frame receiver and consumes its split header/payload output. On each received header it checks the destination MAC against a configured local address, broadcast, and optionally multicast. Matching frames are forwarded, header and payload, with registered outputs. Non-matching frames are silently consumed and counted.

Parameters:
DATA_WIDTH, 8, payload tdata width in bits; must be a multiple of 8.
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_eth_payload_axis_tkeep is driven all ones.
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
DROP_CNT_WIDTH, 32, width of the saturating drop counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
local_mac  input  48  station address; sampled only at header accept
promisc  input  1  accept all frames; sampled at header accept
s_eth_hdr_valid  input  1  header valid
s_eth_hdr_ready  output  1  header ready
s_eth_dest_mac / s_eth_src_mac / s_eth_type  input  48/48/16  header fields
s_eth_payload_axis_tdata/tkeep/tvalid/tlast/tuser  input  DATA_WIDTH/KEEP_WIDTH/1/1/1  payload in
s_eth_payload_axis_tready  output  1  payload ready
m_eth_hdr_valid  output  1  header valid
m_eth_hdr_ready  input  1  header ready
m_eth_dest_mac / m_eth_src_mac / m_eth_type  output  48/48/16  registered header fields
m_eth_payload_axis_tdata/tkeep/tvalid/tlast/tuser  output  DATA_WIDTH/KEEP_WIDTH/1/1/1  payload out
m_eth_payload_axis_tready  input  1  payload ready
frame_drop  output  1  one-cycle pulse when the tlast beat of a dropped frame is consumed
drop_count  output  DROP_CNT_WIDTH  saturating count of dropped frames
busy  output  1  high when the state is not IDLE

Behaviour:
- Reset: state IDLE; s_eth_hdr_ready=0; s_eth_payload_axis_tready=0; m_eth_hdr_valid=0; m_eth_payload_axis_tvalid=0; temp register empty; frame_drop=0; drop_count=0; busy=0. Header data registers are not reset.
- Reset mid-frame: all of the above applies immediately. No partial beats are emitted afterwards.
- FSM has three states: IDLE, FWD, DROP.
- IDLE:
  - s_eth_hdr_ready = !m_eth_hdr_valid || m_eth_hdr_ready. This is registered-equivalent: no combinational path from s_eth_hdr_valid.
  - s_eth_payload_axis_tready=0.
- Match at header accept, evaluated on s_eth_dest_mac:
  - promisc, or dest == local_mac, or dest == 48'hFFFFFFFFFFFF, or (multicast per the Optional Feature).
  - Match: latch fields; m_eth_hdr_valid=1 next cycle; go to FWD.
  - No match: go to DROP; no header is emitted.
- m_eth_hdr_valid clears on the cycle m_eth_hdr_ready is high. The header may remain pending while payload flows.
- FWD:
  - Payload passes through an output register plus a one-entry temp skid register. Latency is 1 cycle.
  - s_eth_payload_axis_tready is registered and computed from output readiness: tready_early = m_ready || (!temp_valid && (!out_valid || !in_valid)).
  - tdata, tkeep, tlast and tuser are copied unchanged.
  - The tlast input transfer returns the FSM to IDLE on the next cycle.
- DROP:
  - s_eth_payload_axis_tready=1 (registered, asserted from the cycle after entry).
  - Beats are discarded.
  - The tlast transfer pulses frame_drop for 1 cycle, increments drop_count (held at all ones when saturated), and returns the FSM to IDLE.
- Minimum inter-frame overhead is 1 bubble cycle: a header cannot be accepted in the cycle of the preceding tlast.
- Frames with tuser=1 are forwarded or dropped by address only; tuser is not acted on.
- A header whose payload is a single tlast beat is handled normally in both FWD and DROP.

Optional Feature:
ETH_RX_DEST_FILTER_MCAST_EN
- Defined: adds input mcast_accept (1 bit). A frame also matches when dest[40]=1 (group bit) and mcast_accept=1, sampled at header accept.
- Undefined: the port is absent. Non-broadcast multicast frames are dropped unless promisc=1.

Test Plan:
- local_mac=02:00:00:00:00:01, header dest=02:00:00:00:00:01, 4 payload beats 0x11..0x44, sink always ready -> header out 1 cycle after accept; 4 beats out in order, each delayed 1 cycle; drop_count=0.
- Same setup, dest=02:00:00:00:00:99 -> no m_eth_hdr_valid; all 4 input beats accepted; frame_drop pulses once; drop_count=1.
- dest=FF:FF:FF:FF:FF:FF, then dest=01:00:5E:00:00:01 with mcast_accept=1 -> broadcast forwarded; multicast forwarded only if MCAST_EN is defined, else drop_count increments.
- Forward a 16-beat frame with m_eth_payload_axis_tready toggling 1010… and m_eth_hdr_ready held 0 for 5 cycles -> no lost or duplicated beats; next header not accepted until the pending header is taken and the current frame ends.
- DROP_CNT_WIDTH=2, 5 consecutive unmatched frames -> drop_count goes 1, 2, 3, 3, 3.
- rst asserted in the 3rd beat of a forwarded frame -> the next cycle shows all valids 0 and busy=0; a following frame forwards correctly.

Source files
------------

// File: rtl/eth_rx_dest_filter.sv
// Drops frames whose dest MAC is not local/broadcast (or accepted multicast with ETH_RX_DEST_FILTER_MCAST_EN).
// Header and payload outputs are registered with 1-cycle latency; payload uses an output register plus a skid entry.
module eth_rx_dest_filter #(
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = (DATA_WIDTH / 8),
  parameter int DROP_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [47:0]               local_mac,
  input  logic                      promisc,
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
  input  logic                      mcast_accept,
`endif
  input  logic                      s_eth_hdr_valid,
  output logic                      s_eth_hdr_ready,
  input  logic [47:0]               s_eth_dest_mac,
  input  logic [47:0]               s_eth_src_mac,
  input  logic [15:0]               s_eth_type,
  input  logic [DATA_WIDTH-1:0]     s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_eth_payload_axis_tkeep,
  input  logic                      s_eth_payload_axis_tvalid,
  output logic                      s_eth_payload_axis_tready,
  input  logic                      s_eth_payload_axis_tlast,
  input  logic                      s_eth_payload_axis_tuser,
  output logic                      m_eth_hdr_valid,
  input  logic                      m_eth_hdr_ready,
  output logic [47:0]               m_eth_dest_mac,
  output logic [47:0]               m_eth_src_mac,
  output logic [15:0]               m_eth_type,
  output logic [DATA_WIDTH-1:0]     m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]     m_eth_payload_axis_tkeep,
  output logic                      m_eth_payload_axis_tvalid,
  input  logic                      m_eth_payload_axis_tready,
  output logic                      m_eth_payload_axis_tlast,
  output logic                      m_eth_payload_axis_tuser,
  output logic                      frame_drop,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t state, state_next;

  logic hdr_ready_reg, hdr_ready_next;
  logic s_tready_reg, s_tready_next;
  logic m_hdr_valid_reg, m_hdr_valid_next;
  logic store_hdr;
  logic frame_drop_reg, frame_drop_next;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;

  logic [47:0] dest_reg, src_reg;
  logic [15:0] type_reg;

  logic [DATA_WIDTH-1:0] out_tdata, temp_tdata;
  logic [KEEP_WIDTH-1:0] out_tkeep, temp_tkeep;
  logic                  out_tlast, temp_tlast, out_tuser, temp_tuser;
  logic                  out_valid, out_valid_next, temp_valid, temp_valid_next;
  logic                  st_in_out, st_in_temp, st_temp_out;

  logic hdr_xfer, pay_xfer, fwd_valid, fwd_rdy, tready_early;
  logic mcast_hit, addr_match;

`ifdef ETH_RX_DEST_FILTER_MCAST_EN
  assign mcast_hit = s_eth_dest_mac[40] && mcast_accept;
`else
  assign mcast_hit = 1'b0;
`endif

  assign addr_match = promisc || (s_eth_dest_mac == local_mac) ||
                      (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF) || mcast_hit;
  assign hdr_xfer   = s_eth_hdr_valid && hdr_ready_reg;
  assign pay_xfer   = s_eth_payload_axis_tvalid && s_tready_reg;
  assign fwd_rdy    = s_tready_reg && (state == FWD);

  always_comb begin
    state_next       = state;
    store_hdr        = 1'b0;
    m_hdr_valid_next = m_hdr_valid_reg && !m_eth_hdr_ready;
    fwd_valid        = 1'b0;
    frame_drop_next  = 1'b0;

    case (state)
      IDLE: begin
        if (hdr_xfer) begin
          if (addr_match) begin
            store_hdr        = 1'b1;
            m_hdr_valid_next = 1'b1;
            state_next       = FWD;
          end else begin
            state_next = DROP;
          end
        end
      end
      FWD: begin
        fwd_valid = pay_xfer;
        if (pay_xfer && s_eth_payload_axis_tlast) state_next = IDLE;
      end
      DROP: begin
        if (pay_xfer && s_eth_payload_axis_tlast) begin
          frame_drop_next = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Ready for next cycle is decided now, so neither input ready depends on an input valid.
    tready_early   = m_eth_payload_axis_tready || (!temp_valid && (!out_valid || !fwd_valid));
    hdr_ready_next = (state_next == IDLE) && !m_hdr_valid_next;
    s_tready_next  = ((state_next == FWD) && tready_early) || (state_next == DROP);

    out_valid_next  = out_valid;
    temp_valid_next = temp_valid;
    st_in_out       = 1'b0;
    st_in_temp      = 1'b0;
    st_temp_out     = 1'b0;
    if (fwd_rdy) begin
      if (m_eth_payload_axis_tready || !out_valid) begin
        out_valid_next = fwd_valid;
        st_in_out      = 1'b1;
      end else begin
        temp_valid_next = fwd_valid;
        st_in_temp      = 1'b1;
      end
    end else if (m_eth_payload_axis_tready) begin
      out_valid_next  = temp_valid;
      temp_valid_next = 1'b0;
      st_temp_out     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      hdr_ready_reg   <= 1'b0;
      s_tready_reg    <= 1'b0;
      m_hdr_valid_reg <= 1'b0;
      out_valid       <= 1'b0;
      temp_valid      <= 1'b0;
      frame_drop_reg  <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      state           <= state_next;
      hdr_ready_reg   <= hdr_ready_next;
      s_tready_reg    <= s_tready_next;
      m_hdr_valid_reg <= m_hdr_valid_next;
      out_valid       <= out_valid_next;
      temp_valid      <= temp_valid_next;
      frame_drop_reg  <= frame_drop_next;
      if (frame_drop_next && (drop_cnt_reg != {DROP_CNT_WIDTH{1'b1}}))
        drop_cnt_reg <= drop_cnt_reg + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Data registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (store_hdr) begin
      dest_reg <= s_eth_dest_mac;
      src_reg  <= s_eth_src_mac;
      type_reg <= s_eth_type;
    end
    if (st_in_out) begin
      out_tdata <= s_eth_payload_axis_tdata;
      out_tkeep <= s_eth_payload_axis_tkeep;
      out_tlast <= s_eth_payload_axis_tlast;
      out_tuser <= s_eth_payload_axis_tuser;
    end else if (st_temp_out) begin
      out_tdata <= temp_tdata;
      out_tkeep <= temp_tkeep;
      out_tlast <= temp_tlast;
      out_tuser <= temp_tuser;
    end
    if (st_in_temp) begin
      temp_tdata <= s_eth_payload_axis_tdata;
      temp_tkeep <= s_eth_payload_axis_tkeep;
      temp_tlast <= s_eth_payload_axis_tlast;
      temp_tuser <= s_eth_payload_axis_tuser;
    end
  end

  assign s_eth_hdr_ready           = hdr_ready_reg;
  assign s_eth_payload_axis_tready = s_tready_reg;
  assign m_eth_hdr_valid           = m_hdr_valid_reg;
  assign m_eth_dest_mac            = dest_reg;
  assign m_eth_src_mac             = src_reg;
  assign m_eth_type                = type_reg;
  assign m_eth_payload_axis_tdata  = out_tdata;
  assign m_eth_payload_axis_tkeep  = (KEEP_ENABLE != 0) ? out_tkeep : {KEEP_WIDTH{1'b1}};
  assign m_eth_payload_axis_tvalid = out_valid;
  assign m_eth_payload_axis_tlast  = out_tlast;
  assign m_eth_payload_axis_tuser  = out_tuser;
  assign frame_drop                = frame_drop_reg;
  assign drop_count                = drop_cnt_reg;
  assign busy                      = (state != IDLE);

endmodule

// File: tb/tb_eth_rx_dest_filter.sv
// Bench for eth_rx_dest_filter: directed frames checked against a queue-based frame model every cycle.
module tb_eth_rx_dest_filter;
  localparam int DW  = 8;
  localparam int KW  = 1;
  localparam int DCW = 2;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [47:0] local_mac;
  logic promisc;
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
  logic mcast_accept;
`endif
  logic s_eth_hdr_valid, s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac, s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic s_tvalid, s_tready, s_tlast, s_tuser;
  logic m_eth_hdr_valid, m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tvalid, m_tready, m_tlast, m_tuser;
  logic frame_drop, busy;
  logic [DCW-1:0] drop_count;

  eth_rx_dest_filter #(.DATA_WIDTH(DW), .DROP_CNT_WIDTH(DCW)) dut (
    .clk(clk), .rst(rst), .local_mac(local_mac), .promisc(promisc),
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
    .mcast_accept(mcast_accept),
`endif
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .frame_drop(frame_drop), .drop_count(drop_count), .busy(busy)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed { logic [47:0] d; logic [47:0] s; logic [15:0] t; } hdr_s;
  typedef struct { logic [7:0] d; logic l; logic u; int stamp; } beat_s;
  hdr_s hq[$];
  beat_s pq[$];
  logic [7:0]  out_log[$];
  logic [47:0] hdr_log[$];
  bit m_busy = 0, m_fwd = 0, m_pulse = 0;
  int m_cnt = 0, cyc = 0, pulse_cnt = 0, acc_cnt = 0;
  bit mon_en = 0, lat_chk = 0, tog = 0;

  function automatic bit model_match(input logic [47:0] d);
    bit mc = 0;
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
    mc = d[40] && mcast_accept;
`endif
    return promisc || (d == local_mac) || (d == BCAST) || mc;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      check("busy", busy, m_busy);
      check("frame_drop", frame_drop, m_pulse);
      check("drop_count", drop_count, m_cnt);
      check("hdr_valid", m_eth_hdr_valid, hq.size() > 0);
      if (m_eth_hdr_valid === 1'b1 && hq.size() > 0)
        check("hdr_fields", {m_eth_dest_mac, m_eth_src_mac, m_eth_type}, hq[0]);
      if (s_eth_hdr_ready === 1'b1 && (m_busy || hq.size() > 0))
        check("hdr_ready_while_pending", s_eth_hdr_ready, 0);
      if (s_tready === 1'b1 && !m_busy)
        check("tready_outside_frame", s_tready, 0);
      if (m_tvalid !== 1'b0) begin
        if (pq.size() == 0) check("phantom_beat", m_tvalid, 0);
        else begin
          check("beat", {m_tdata, m_tlast, m_tuser, m_tkeep}, {pq[0].d, pq[0].l, pq[0].u, 1'b1});
          if (lat_chk) check("beat_latency", cyc, pq[0].stamp + 1);
        end
      end
      if (frame_drop === 1'b1) pulse_cnt++;

      // predict what the coming edge does
      if (rst) begin
        m_busy = 0; m_fwd = 0; m_pulse = 0; m_cnt = 0;
        hq.delete(); pq.delete();
      end else begin
        m_pulse = 0;
        if (m_tvalid && m_tready && pq.size() > 0) begin
          out_log.push_back(m_tdata);
          void'(pq.pop_front());
        end
        if (m_eth_hdr_valid && m_eth_hdr_ready && hq.size() > 0) begin
          hdr_log.push_back(m_eth_dest_mac);
          void'(hq.pop_front());
        end
        if (s_eth_hdr_valid && s_eth_hdr_ready) begin
          acc_cnt++;
          m_busy = 1;
          m_fwd  = model_match(s_eth_dest_mac);
          if (m_fwd) hq.push_back({s_eth_dest_mac, s_eth_src_mac, s_eth_type});
        end
        if (s_tvalid && s_tready && m_busy) begin
          if (m_fwd) pq.push_back('{s_tdata, s_tlast, s_tuser, cyc});
          if (s_tlast) begin
            m_busy = 0;
            if (!m_fwd) begin
              m_pulse = 1;
              if (m_cnt < (1 << DCW) - 1) m_cnt++;
            end
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = tog ? ~m_tready : 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [47:0] d);
    int n = 0;
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac  = d;
    s_eth_src_mac   = {40'h0A_0B_0C_0D_0E, d[7:0]};
    s_eth_type      = {8'h08, d[7:0]};
    @(negedge clk);
    while (s_eth_hdr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("hdr_accept_timeout", s_eth_hdr_ready, 1);
    @(posedge clk); #1;
    s_eth_hdr_valid = 1'b0;
  endtask

  task automatic send_pay(input int nb, input logic [7:0] base, input logic [7:0] step, input logic user);
    for (int i = 0; i < nb; i++) begin
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = 8'(base + i * step);
      s_tlast  = (i == nb - 1);
      s_tuser  = user && (i == nb - 1);
      @(negedge clk);
      while (s_tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("beat_accept_timeout", s_tready, 1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  logic [7:0] exp1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int exp5 [5] = '{1, 2, 3, 3, 3};

  initial begin
    int base_out, base_hdr, acc0;
    bit hdr_done;
    local_mac = LOCAL; promisc = 1'b0;
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
    mcast_accept = 1'b0;
`endif
    s_eth_hdr_valid = 1'b0; s_eth_dest_mac = '0; s_eth_src_mac = '0; s_eth_type = '0;
    s_tdata = '0; s_tkeep = '1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_eth_hdr_ready = 1'b1;

    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    check("rst_hdr_ready", s_eth_hdr_ready, 0);
    check("rst_tready", s_tready, 0);
    check("rst_m_hdr_valid", m_eth_hdr_valid, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_count", drop_count, 0);
    rst = 1'b0;

    // local match, 4 beats, always-ready sink
    lat_chk = 1;
    send_hdr(LOCAL);
    send_pay(4, 8'h11, 8'h11, 1'b0);
    idle(4);
    lat_chk = 0;
    check("t1_out_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check("t1_beat_value", out_log[i], exp1[i]);
    check("t1_hdr_dest", hdr_log.size() > 0 ? hdr_log[0] : 48'h0, LOCAL);
    check("t1_drop_count", drop_count, 0);

    // unmatched unicast
    send_hdr(48'h02_00_00_00_00_99);
    send_pay(4, 8'h11, 8'h11, 1'b0);
    idle(3);
    check("t2_hdr_count", hdr_log.size(), 1);
    check("t2_out_count", out_log.size(), 4);
    check("t2_pulses", pulse_cnt, 1);
    check("t2_drop_count", drop_count, 1);

    // broadcast, then multicast with mcast_accept
    send_hdr(BCAST);
    send_pay(2, 8'h50, 8'h01, 1'b0);
    idle(3);
    check("t3_bcast_hdr", hdr_log.size() > 1 ? hdr_log[1] : 48'h0, BCAST);
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
    mcast_accept = 1'b1;
`endif
    send_hdr(48'h01_00_5E_00_00_01);
    send_pay(2, 8'h60, 8'h01, 1'b0);
    idle(3);
`ifdef ETH_RX_DEST_FILTER_MCAST_EN
    mcast_accept = 1'b0;
    check("t3_mcast_hdr_count", hdr_log.size(), 3);
    check("t3_mcast_drop_count", drop_count, 1);
`else
    check("t3_mcast_hdr_count", hdr_log.size(), 2);
    check("t3_mcast_drop_count", drop_count, 2);
`endif

    // promiscuous single-beat frame with tuser set
    base_hdr = hdr_log.size();
    base_out = out_log.size();
    promisc = 1'b1;
    send_hdr(48'h00_00_00_00_00_AA);
    promisc = 1'b0;
    send_pay(1, 8'hA5, 8'h00, 1'b1);
    idle(3);
    check("t_promisc_hdr", hdr_log.size(), base_hdr + 1);
    check("t_promisc_beat", out_log.size() > base_out ? out_log[base_out] : 8'h00, 8'hA5);

    // 16 beats, toggling sink, header held back 5 cycles
    base_out = out_log.size();
    m_eth_hdr_ready = 1'b0;
    tog = 1;
    send_hdr(LOCAL);
    fork
      send_pay(16, 8'h80, 8'h01, 1'b0);
      begin repeat (5) @(posedge clk); #1; m_eth_hdr_ready = 1'b1; end
    join
    idle(6);
    tog = 0;
    idle(1);
    check("t4_out_count", out_log.size(), base_out + 16);
    for (int i = 0; i < 16 && base_out + i < out_log.size(); i++)
      check("t4_beat_order", out_log[base_out + i], 8'(8'h80 + i));

    // pending header blocks the next header accept
    m_eth_hdr_ready = 1'b0;
    send_hdr(LOCAL);
    send_pay(1, 8'hC0, 8'h00, 1'b0);
    acc0 = acc_cnt;
    hdr_done = 0;
    fork
      begin send_hdr(BCAST); hdr_done = 1; end
    join_none
    idle(6);
    check("pending_blocks_hdr", acc_cnt, acc0);
    m_eth_hdr_ready = 1'b1;
    for (int k = 0; k < 50 && !hdr_done; k++) @(posedge clk);
    #2;
    check("pending_released_hdr", acc_cnt, acc0 + 1);
    send_pay(1, 8'hC1, 8'h00, 1'b0);
    idle(3);

    // saturation of the 2-bit drop counter
    rst = 1'b1; idle(1); rst = 1'b0; idle(1);
    for (int i = 0; i < 5; i++) begin
      send_hdr(48'h02_00_00_00_01_00 + 48'(i));
      send_pay(i == 0 ? 1 : 2, 8'h30, 8'h01, 1'b0);
      idle(2);
      check("t5_drop_count", drop_count, exp5[i]);
    end

    // reset during the third beat of a forwarded frame
    rst = 1'b1; idle(1); rst = 1'b0; idle(1);
    send_hdr(LOCAL);
    send_pay(2, 8'hB0, 8'h01, 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'hB2; s_tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_tvalid = 1'b0;
    check("t6_hdr_valid", m_eth_hdr_valid, 0);
    check("t6_tvalid", m_tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_tready", s_tready, 0);
    idle(1);
    base_out = out_log.size();
    send_hdr(LOCAL);
    send_pay(3, 8'hD0, 8'h01, 1'b0);
    idle(4);
    check("t6_out_count", out_log.size(), base_out + 3);
    for (int i = 0; i < 3 && base_out + i < out_log.size(); i++)
      check("t6_beat_value", out_log[base_out + i], 8'(8'hD0 + i));

    check("end_payload_drained", pq.size(), 0);
    check("end_hdr_drained", hq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #300000;
    nfail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $fatal(1, "watchdog");
  end

endmodule
